// File: rtl/capture_readback_spi_slave_if.sv
// rtl/capture_readback_spi_slave_if.sv - SPI host pins and capture-buffer read port bundle
interface capture_readback_spi_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              spi_read;
  logic [ADDR_W-1:0] spi_address;
  logic [DATA_W-1:0] spi_data_in;
  logic              word_done;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, spi_data_in,
    output spi_miso, spi_miso_oe, spi_read, spi_address, word_done
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, spi_data_in,
    input  spi_miso, spi_miso_oe, spi_read, spi_address, word_done
  );
endinterface

// File: rtl/capture_readback_spi_slave.sv
// rtl/capture_readback_spi_slave.sv - oversampled mode-0 SPI slave reading capture words by address
// Optional macro READBACK_PARITY_EN appends an even-parity bit after each word's LSB.
module capture_readback_spi_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 12,
  parameter int RD_LATENCY  = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic                          clk,
  input logic                          rst,
  capture_readback_spi_slave_if.slave  bus
);

`ifdef READBACK_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam int MAX_W = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int LAT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, ADDR, ISSUE, WAIT, DATA} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   rise;
  logic                   fall;
  logic                   armed;
  logic                   skip_fall;
  logic [CNT_W-1:0]       bit_cnt;
  logic [LAT_W-1:0]       lat_cnt;
  logic [ADDR_W-2:0]      addr_sr;
  logic [WORD_W-2:0]      data_sr;
  logic [WORD_W-1:0]      load_word;
  logic                   miso_q;
  logic                   oe_q;
  logic                   read_q;
  logic                   done_q;
  logic [ADDR_W-1:0]      addr_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

`ifdef READBACK_PARITY_EN
  assign load_word = {bus.spi_data_in, ^bus.spi_data_in};
`else
  assign load_word = bus.spi_data_in;
`endif

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.spi_read    = read_q;
  assign bus.spi_address = addr_q;
  assign bus.word_done   = done_q;

  // cs_n chain resets low so a CS held low through reset never looks like a fresh select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      skip_fall <= 1'b0;
      bit_cnt   <= '0;
      lat_cnt   <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      read_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      read_q <= 1'b0;
      done_q <= 1'b0;
      if (cs_s) armed <= 1'b1;

      // Deselect wins over any edge seen in the same cycle
      if (cs_s && state != IDLE) begin
        state     <= IDLE;
        skip_fall <= 1'b0;
        bit_cnt   <= '0;
        lat_cnt   <= '0;
        addr_sr   <= '0;
        data_sr   <= '0;
        miso_q    <= 1'b0;
        oe_q      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            if (!cs_s && armed) state <= ADDR;
          end
          ADDR: begin
            if (rise) begin
              if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                addr_q  <= {addr_sr, mosi_s};
                bit_cnt <= '0;
                state   <= ISSUE;
              end else begin
                addr_sr <= {addr_sr[ADDR_W-3:0], mosi_s};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ISSUE: begin
            read_q  <= 1'b1;
            lat_cnt <= '0;
            state   <= WAIT;
          end
          WAIT: begin
            if (lat_cnt == LAT_W'(RD_LATENCY)) begin
              miso_q    <= load_word[WORD_W-1];
              data_sr   <= load_word[WORD_W-2:0];
              oe_q      <= 1'b1;
              skip_fall <= 1'b1;
              bit_cnt   <= '0;
              state     <= DATA;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          DATA: begin
            if (rise) begin
              if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                done_q    <= 1'b1;
                addr_q    <= addr_q + 1'b1;
                bit_cnt   <= '0;
                skip_fall <= 1'b1;
                state     <= ISSUE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (fall) begin
              // The first fall is the mode-0 turnaround; the MSB is already on MISO
              if (skip_fall) begin
                skip_fall <= 1'b0;
              end else begin
                miso_q  <= data_sr[WORD_W-2];
                data_sr <= {data_sr[WORD_W-3:0], 1'b0};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_readback_spi_slave.sv
// tb/tb_capture_readback_spi_slave.sv - directed bench for capture_readback_spi_slave
module tb_capture_readback_spi_slave;

`ifdef READBACK_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rd_cnt = 0;
  int   wd_cnt = 0;
  int   r0;
  int   w0;
  logic [7:0]  rd_log [0:31];
  logic [11:0] mem [0:127];
  logic [12:0] w;

  capture_readback_spi_slave_if #(.ADDR_W(8), .DATA_W(12)) ifc ();

  capture_readback_spi_slave #(
    .ADDR_W(8), .DATA_W(12), .RD_LATENCY(1), .SYNC_STAGES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Storage depth is 128; higher addresses read as zero
  assign ifc.spi_data_in = ifc.spi_address[7] ? 12'h000 : mem[ifc.spi_address[6:0]];

  always @(posedge clk) begin
    if (ifc.spi_read) begin
      if (rd_cnt < 32) rd_log[rd_cnt] = ifc.spi_address;
      rd_cnt = rd_cnt + 1;
    end
    if (ifc.word_done) wd_cnt = wd_cnt + 1;
  end

  function automatic logic [12:0] expw(input logic [11:0] d);
`ifdef READBACK_PARITY_EN
    return {d, ^d};
`else
    return {1'b0, d};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_addr(input logic [7:0] a, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      ifc.spi_mosi = a[i];
      tick(HALF);
      ifc.spi_sclk = 1'b1;
      tick(HALF);
      ifc.spi_sclk = 1'b0;
    end
  endtask

  // last=1 drops CS one clk after the final rise so no follow-on read is issued
  task automatic read_word(output logic [12:0] word, input bit last);
    word = '0;
    for (int i = 0; i < NB; i++) begin
      tick(HALF);
      word = {word[11:0], ifc.spi_miso};
      ifc.spi_sclk = 1'b1;
      if (last && i == NB - 1) begin
        tick(1);
        ifc.spi_cs_n = 1'b1;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      ifc.spi_sclk = 1'b0;
    end
    if (last) tick(8);
  endtask

  task automatic frame(input logic [7:0] a, input string tag, input logic [11:0] d);
    r0 = rd_cnt;
    w0 = wd_cnt;
    ifc.spi_cs_n = 1'b0;
    send_addr(a, 8);
    read_word(w, 1'b1);
    check({tag, "_word"}, {19'd0, w}, {19'd0, expw(d)});
    check({tag, "_reads"}, rd_cnt - r0, 1);
    check({tag, "_addr"}, {24'd0, rd_log[r0]}, {24'd0, a});
    check({tag, "_done"}, wd_cnt - w0, 1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 12'h000;
    mem[7'h00] = 12'hFFF;
    mem[7'h01] = 12'h001;
    mem[7'h05] = 12'hA5C;
    mem[7'h10] = 12'h3C7;
    mem[7'h7E] = 12'h123;
    mem[7'h7F] = 12'h456;
    ifc.spi_sclk = 1'b0;
    ifc.spi_cs_n = 1'b1;
    ifc.spi_mosi = 1'b0;

    tick(3);
    check("rst_miso", {31'd0, ifc.spi_miso}, 0);
    check("rst_oe", {31'd0, ifc.spi_miso_oe}, 0);
    check("rst_read", {31'd0, ifc.spi_read}, 0);
    check("rst_addr", {24'd0, ifc.spi_address}, 0);
    check("rst_done", {31'd0, ifc.word_done}, 0);
    rst = 1'b0;
    tick(8);

    // Single read at 0x05, MSB already presented at the turnaround
    r0 = rd_cnt;
    w0 = wd_cnt;
    ifc.spi_cs_n = 1'b0;
    send_addr(8'h05, 8);
    check("single_oe_data", {31'd0, ifc.spi_miso_oe}, 1);
    check("single_msb", {31'd0, ifc.spi_miso}, 1);
    read_word(w, 1'b1);
    check("single_word", {19'd0, w}, {19'd0, expw(12'hA5C)});
    check("single_reads", rd_cnt - r0, 1);
    check("single_addr", {24'd0, rd_log[r0]}, 32'h05);
    check("single_done", wd_cnt - w0, 1);
    check("single_oe_off", {31'd0, ifc.spi_miso_oe}, 0);
    check("single_miso_off", {31'd0, ifc.spi_miso}, 0);

    // Burst of three from 0x7E; 0x80 is beyond depth
    r0 = rd_cnt;
    w0 = wd_cnt;
    ifc.spi_cs_n = 1'b0;
    send_addr(8'h7E, 8);
    read_word(w, 1'b0);
    check("burst_w0", {19'd0, w}, {19'd0, expw(12'h123)});
    read_word(w, 1'b0);
    check("burst_w1", {19'd0, w}, {19'd0, expw(12'h456)});
    read_word(w, 1'b1);
    check("burst_w2", {19'd0, w}, {19'd0, expw(12'h000)});
    check("burst_reads", rd_cnt - r0, 3);
    check("burst_a0", {24'd0, rd_log[r0]}, 32'h7E);
    check("burst_a1", {24'd0, rd_log[r0+1]}, 32'h7F);
    check("burst_a2", {24'd0, rd_log[r0+2]}, 32'h80);
    check("burst_done", wd_cnt - w0, 3);

    // Address wrap 0xFF -> 0x00
    r0 = rd_cnt;
    ifc.spi_cs_n = 1'b0;
    send_addr(8'hFF, 8);
    read_word(w, 1'b0);
    check("wrap_w0", {19'd0, w}, {19'd0, expw(12'h000)});
    read_word(w, 1'b1);
    check("wrap_w1", {19'd0, w}, {19'd0, expw(12'hFFF)});
    check("wrap_a0", {24'd0, rd_log[r0]}, 32'hFF);
    check("wrap_a1", {24'd0, rd_log[r0+1]}, 32'h00);
    check("wrap_addr_out", {24'd0, ifc.spi_address}, 32'h01);

    // Abort after five address bits
    r0 = rd_cnt;
    ifc.spi_cs_n = 1'b0;
    send_addr(8'hAA, 5);
    ifc.spi_cs_n = 1'b1;
    tick(40);
    check("abort_reads", rd_cnt - r0, 0);
    check("abort_oe", {31'd0, ifc.spi_miso_oe}, 0);
    frame(8'h10, "after_abort", 12'h3C7);

    // Parity bit for 0x001 is 1 when enabled
    frame(8'h01, "low_word", 12'h001);

    // Reset during DATA after six bits
    ifc.spi_cs_n = 1'b0;
    send_addr(8'h05, 8);
    for (int i = 0; i < 6; i++) begin
      tick(HALF);
      ifc.spi_sclk = 1'b1;
      tick(HALF);
      ifc.spi_sclk = 1'b0;
    end
    tick(2);
    rst = 1'b1;
    #1;
    check("mid_rst_oe", {31'd0, ifc.spi_miso_oe}, 0);
    check("mid_rst_miso", {31'd0, ifc.spi_miso}, 0);
    check("mid_rst_addr", {24'd0, ifc.spi_address}, 0);
    check("mid_rst_read", {31'd0, ifc.spi_read}, 0);
    tick(3);
    rst = 1'b0;
    r0 = rd_cnt;
    send_addr(8'h05, 8);
    tick(4 * HALF);
    check("held_cs_reads", rd_cnt - r0, 0);
    check("held_cs_oe", {31'd0, ifc.spi_miso_oe}, 0);
    ifc.spi_cs_n = 1'b1;
    tick(8);
    frame(8'h7F, "after_rst", 12'h456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
